// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial flash target: READ, PAGE PROGRAM, WREN, WRDI, RDSR on an internal byte array.
// SCK, CS and MOSI are oversampled by clk; SCK is treated purely as data.
module spi_flash_responder #(
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned PAGE_AW     = 8,
  parameter int unsigned PROG_CYCLES = 48000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_SPI_CLK,
  input  logic              i_SPI_MOSI,
  input  logic              i_SPI_CS,
  output logic              o_SPI_MISO,
  output logic              o_MISO_OE,
  input  logic              i_load_en,
  input  logic [MEM_AW-1:0] i_load_addr,
  input  logic [7:0]        i_load_data,
  output logic              o_busy,
  output logic              o_wel
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam int unsigned CNT_W = $clog2(PROG_CYCLES + 1);
  localparam int unsigned RX_W  = MEM_AW - 1;

  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;

  typedef enum logic [2:0] {
    ST_IGNORE, ST_IDLE, ST_CMD, ST_ADDR, ST_RD, ST_PG, ST_STATUS, ST_WEN
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sck_sync, cs_sync;
  logic [1:0]        mosi_sync;
  logic              sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
  logic [RX_W-1:0]   rx_sr;
  logic [MEM_AW-1:0] rx_word_c;
  logic [4:0]        bit_cnt;
  logic [7:0]        op_q;
  logic [MEM_AW-1:0] addr_q;
  logic [6:0]        tx_sr;
  logic [2:0]        tx_cnt;
  logic [CNT_W-1:0]  busy_cnt;
  logic              pg_any, wen_extra;
  logic              pg_we_c;
  logic [MEM_AW-1:0] rd_addr_c;
  logic [7:0]        tx_byte_c;
  logic [7:0]        mem [DEPTH];

  // Two-flop synchronisers plus one history flop for edge detection; CS resets low so a
  // CS already asserted at reset release produces no falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], i_SPI_CLK};
      cs_sync   <= {cs_sync[1:0], i_SPI_CS};
      mosi_sync <= {mosi_sync[0], i_SPI_MOSI};
    end
  end

  assign sck_rise  = sck_sync[1] & ~sck_sync[2];
  assign sck_fall  = ~sck_sync[1] & sck_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign mosi_s    = mosi_sync[1];
  assign rx_word_c = {rx_sr, mosi_s};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IGNORE;
    else        state_q <= state_d;
  end

  // Next state, program-write strobe and outgoing byte selection
  always_comb begin
    state_d   = state_q;
    pg_we_c   = 1'b0;
    rd_addr_c = o_MISO_OE ? addr_q + MEM_AW'(1) : addr_q;
    tx_byte_c = (state_q == ST_RD) ? mem[rd_addr_c] : {6'b0, o_wel, o_busy};
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (sck_rise && bit_cnt == 5'd7) begin
            if (rx_word_c[7:0] == OP_RDSR)                               state_d = ST_STATUS;
            else if (o_busy)                                             state_d = ST_IGNORE;
            else if (rx_word_c[7:0] == OP_READ)                          state_d = ST_ADDR;
            else if (rx_word_c[7:0] == OP_PP)                            state_d = o_wel ? ST_ADDR : ST_IGNORE;
            else if (rx_word_c[7:0] == OP_WREN || rx_word_c[7:0] == OP_WRDI) state_d = ST_WEN;
            else                                                         state_d = ST_IGNORE;
          end
        end
        ST_ADDR: if (sck_rise && bit_cnt == 5'd23) state_d = (op_q == OP_READ) ? ST_RD : ST_PG;
        ST_PG:   pg_we_c = sck_rise && (bit_cnt == 5'd7);
        default: ;
      endcase
    end
  end

  // Shift registers, address pointer, MISO driver, status bits and busy timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sr      <= '0;
      bit_cnt    <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      tx_sr      <= '0;
      tx_cnt     <= '0;
      busy_cnt   <= '0;
      pg_any     <= 1'b0;
      wen_extra  <= 1'b0;
      o_SPI_MISO <= 1'b0;
      o_MISO_OE  <= 1'b0;
      o_busy     <= 1'b0;
      o_wel      <= 1'b0;
    end else begin
      if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - CNT_W'(1);
        if (busy_cnt == CNT_W'(1)) o_busy <= 1'b0;
      end
      if (cs_rise) begin
        // End of transaction: release MISO, drop any partial byte, commit WEL/program effects
        o_MISO_OE  <= 1'b0;
        o_SPI_MISO <= 1'b0;
        bit_cnt    <= '0;
        if (state_q == ST_PG && bit_cnt == 5'd0 && pg_any) begin
          o_busy   <= 1'b1;
          busy_cnt <= CNT_W'(PROG_CYCLES);
          o_wel    <= 1'b0;
        end
        if (state_q == ST_WEN && !wen_extra) o_wel <= (op_q == OP_WREN);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall) begin
              bit_cnt   <= '0;
              tx_cnt    <= '0;
              pg_any    <= 1'b0;
              wen_extra <= 1'b0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              rx_sr <= rx_word_c[RX_W-1:0];
              if (bit_cnt == 5'd7) begin
                op_q    <= rx_word_c[7:0];
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              rx_sr <= rx_word_c[RX_W-1:0];
              if (bit_cnt == 5'd23) begin
                addr_q  <= rx_word_c;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ST_RD, ST_STATUS: begin
            if (sck_fall) begin
              if (!o_MISO_OE || tx_cnt == 3'd7) begin
                tx_sr      <= tx_byte_c[6:0];
                o_SPI_MISO <= tx_byte_c[7];
                o_MISO_OE  <= 1'b1;
                tx_cnt     <= '0;
                if (state_q == ST_RD) addr_q <= rd_addr_c;
              end else begin
                o_SPI_MISO <= tx_sr[6];
                tx_sr      <= {tx_sr[5:0], 1'b0};
                tx_cnt     <= tx_cnt + 3'd1;
              end
            end
          end
          ST_PG: begin
            if (sck_rise) begin
              rx_sr <= rx_word_c[RX_W-1:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt                <= '0;
                pg_any                 <= 1'b1;
                addr_q[PAGE_AW-1:0]    <= addr_q[PAGE_AW-1:0] + PAGE_AW'(1);
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ST_WEN: if (sck_rise) wen_extra <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Byte array: backdoor load (only while CS is deasserted) wins over SPI program writes
  always_ff @(posedge clk) begin
    if (i_load_en && cs_sync[1]) mem[i_load_addr] <= i_load_data;
    else if (pg_we_c)            mem[addr_q]      <= rx_word_c[7:0];
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: reads, status, write enable, page program, wraps, reset.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck, mosi, cs;
  logic        miso, oe, busy, wel;
  logic        load_en;
  logic [11:0] load_addr;
  logic [7:0]  load_data;
  logic [7:0]  r;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          hp     = 6;
  int          cnt;

  always #5 clk = ~clk;

  spi_flash_responder #(.MEM_AW(12), .PAGE_AW(8), .PROG_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .i_SPI_CLK(sck), .i_SPI_MOSI(mosi), .i_SPI_CS(cs),
    .o_SPI_MISO(miso), .o_MISO_OE(oe),
    .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data),
    .o_busy(busy), .o_wel(wel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk); load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk); load_en = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); mosi = tx[7-i];
      repeat (hp) @(negedge clk);
      rx = {rx[6:0], miso}; sck = 1'b1;
      repeat (hp) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    @(negedge clk); cs = 1'b0;
    repeat (hp) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (hp) @(negedge clk);
    cs = 1'b1;
    repeat (hp) @(negedge clk);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    spi_xfer(op, 8, d);
    spi_xfer(a[23:16], 8, d);
    spi_xfer(a[15:8], 8, d);
    spi_xfer(a[7:0], 8, d);
  endtask

  task automatic one_cmd(input logic [7:0] op);
    logic [7:0] d;
    cs_start(); spi_xfer(op, 8, d); cs_end();
  endtask

  task automatic read1(input logic [23:0] a, output logic [7:0] d);
    cs_start(); hdr(8'h03, a); spi_xfer(8'h00, 8, d); cs_end();
  endtask

  initial begin
    reset = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    check("rst_oe", oe, 0);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check("rst_wel", wel, 0);
    reset = 1'b1;
    repeat (8) @(negedge clk);

    // streaming read of two backdoor-loaded bytes
    load(12'h123, 8'hA5);
    load(12'h124, 8'h3C);
    cs_start(); hdr(8'h03, 24'h000123);
    spi_xfer(8'h00, 8, r); check("rd_123", r, 8'hA5);
    check("rd_oe_on", oe, 1);
    spi_xfer(8'h00, 8, r); check("rd_124", r, 8'h3C);
    @(negedge clk); cs = 1'b1;
    repeat (3) @(negedge clk);
    check("oe_off_3clk", oe, 0);
    repeat (hp) @(negedge clk);

    // write enable / disable and status readback
    one_cmd(8'h06);
    check("wel_set", wel, 1);
    cs_start(); spi_xfer(8'h05, 8, r); spi_xfer(8'h00, 8, r); cs_end();
    check("status_wel", r, 8'h02);
    one_cmd(8'h04);
    check("wel_clr", wel, 0);
    cs_start(); spi_xfer(8'h05, 8, r); spi_xfer(8'h00, 8, r); cs_end();
    check("status_zero", r, 8'h00);

    // program without write enable is ignored
    load(12'h010, 8'h5A);
    cs_start(); hdr(8'h02, 24'h000010); spi_xfer(8'h55, 8, r); cs_end();
    check("nowel_busy", busy, 0);
    read1(24'h000010, r); check("nowel_mem", r, 8'h5A);

    // page program with in-page wrap, busy duration
    one_cmd(8'h06);
    cs_start(); hdr(8'h02, 24'h0000FE);
    spi_xfer(8'h11, 8, r); spi_xfer(8'h22, 8, r); spi_xfer(8'h33, 8, r);
    repeat (hp) @(negedge clk);
    cs = 1'b1;
    cnt = 0;
    while (!busy && cnt < 10) begin cnt++; @(negedge clk); end
    cnt = 0;
    while (busy && cnt < 300) begin cnt++; @(negedge clk); end
    check("busy_cycles", cnt, 100);
    check("pg_wel_clr", wel, 0);
    read1(24'h0000FE, r); check("pg_0fe", r, 8'h11);
    read1(24'h0000FF, r); check("pg_0ff", r, 8'h22);
    read1(24'h000000, r); check("pg_000", r, 8'h33);

    // read issued while busy is ignored
    hp = 4;
    one_cmd(8'h06);
    cs_start(); hdr(8'h02, 24'h000020); spi_xfer(8'h99, 8, r);
    repeat (hp) @(negedge clk);
    cs = 1'b1;
    repeat (hp) @(negedge clk);
    cs_start(); spi_xfer(8'h03, 8, r);
    check("busy_at_op", busy, 1);
    spi_xfer(8'h00, 8, r); spi_xfer(8'h01, 8, r); spi_xfer(8'h23, 8, r);
    spi_xfer(8'h00, 8, r);
    check("busy_rd_oe", oe, 0);
    cs_end();
    hp = 6;
    repeat (120) @(negedge clk);

    // program ending mid-byte: byte kept, no busy, WEL kept
    one_cmd(8'h06);
    cs_start(); hdr(8'h02, 24'h000040);
    spi_xfer(8'hAB, 8, r); spi_xfer(8'hFF, 4, r); cs_end();
    check("part_busy", busy, 0);
    check("part_wel", wel, 1);
    read1(24'h000040, r); check("part_mem", r, 8'hAB);

    // read wraps at the end of the array
    load(12'hFFF, 8'h77);
    load(12'h000, 8'h88);
    cs_start(); hdr(8'h03, 24'h000FFF);
    spi_xfer(8'h00, 8, r); check("wrap_fff", r, 8'h77);
    spi_xfer(8'h00, 8, r); check("wrap_000", r, 8'h88);
    cs_end();

    // reset mid-read with CS held low
    load(12'h200, 8'hC3);
    cs_start(); hdr(8'h03, 24'h000200);
    spi_xfer(8'h00, 4, r);
    check("pre_rst_oe", oe, 1);
    @(negedge clk); reset = 1'b0;
    #1;
    check("mid_rst_oe", oe, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wel", wel, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    spi_xfer(8'h03, 8, r);
    spi_xfer(8'h00, 8, r);
    check("post_rst_ignore_oe", oe, 0);
    cs_end();
    read1(24'h000200, r); check("post_rst_rd", r, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI Mode 0 target that models the serial flash seen by the 6809 flash controller.
- Sits on the target end of the SPI bus and answers READ (0x03), PAGE PROGRAM (0x02), WRITE ENABLE (0x06), WRITE DISABLE (0x04) and READ STATUS (0x05) from an internal byte array.
- Used as an on-FPGA flash substitute and as the bus-functional responder in controller benches.
- Samples SCK, CS and MOSI with the system clock; SCK is never used as a clock.

Parameters:
MEM_AW, 12, memory address width; array depth is 2^MEM_AW bytes; SPI address bits [MEM_AW-1:0] are used, upper bits ignored
PAGE_AW, 8, page size 2^PAGE_AW bytes; program address wraps inside the page
PROG_CYCLES, 48000, clk cycles the busy flag (WIP) stays set after a valid page program

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
i_SPI_CLK  input  1  SPI clock from master, idles low
i_SPI_MOSI  input  1  master out, target in
i_SPI_CS  input  1  chip select, active low
o_SPI_MISO  output  1  target out, master in
o_MISO_OE  output  1  MISO drive enable; the top level tri-states MISO when low
i_load_en  input  1  backdoor write strobe, one byte per clk
i_load_addr  input  MEM_AW  backdoor write address
i_load_data  input  8  backdoor write data
o_busy  output  1  WIP status bit
o_wel  output  1  write-enable-latch status bit

Behaviour:
- Input synchronisation:
  - SCK, CS and MOSI each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised copies.
  - Requirement: SCK high and low phases are each ≥4 clk cycles.
- Reset values: o_SPI_MISO=0, o_MISO_OE=0, o_busy=0, o_wel=0, state=IGNORE, busy counter=0. The memory array is not reset.
- Transaction start: only on a synchronised CS falling edge. After reset, CS already low leaves the block in IGNORE until CS rises.
- Sampling: MOSI is sampled on each SCK rising edge, MSB first. MISO changes only after SCK falling edges.
- States:
  - IDLE: CS high. On CS fall → CMD, bit count cleared.
  - CMD: shifts 8 bits. On the 8th rising edge, decode:
    - 0x05 → STATUS.
    - If busy=1, any other opcode → IGNORE.
    - 0x03 → ADDR (read).
    - 0x02 with wel=1 → ADDR (program).
    - 0x02 with wel=0 → IGNORE.
    - 0x06 or 0x04 → WEN (latch updates on the CS rise that ends the command).
    - Any other opcode → IGNORE.
  - ADDR: shifts 24 bits, MSB first. On the 24th rising edge, latch the address → RD or PG.
  - RD:
    - On the falling edge after the last address bit, load the shift register with mem[addr]. Drive bit7 with o_MISO_OE=1.
    - Each subsequent falling edge shifts out the next bit.
    - After the 8th bit, addr = addr+1 modulo 2^MEM_AW and the next byte loads. Streaming continues until CS rises.
  - PG:
    - Each complete 8-bit byte is written to mem[{page, offset}].
    - Offset increments modulo 2^PAGE_AW; the page bits never change.
    - The data byte count is tracked.
  - STATUS: shifts out {6'b0, wel, busy}, repeated every 8 bits, with live values reloaded at each byte boundary.
  - WEN: waits for CS rise. If exactly 8 bits were received, 0x06 sets wel and 0x04 clears it. Otherwise no change.
  - IGNORE: MISO not driven; waits for CS rise.
- CS rise in any state → IDLE and o_MISO_OE=0 in the same clk.
  - A partial byte is discarded.
  - PG ending on a byte boundary with ≥1 data byte: busy=1, counter=PROG_CYCLES, wel=0.
  - PG ending mid-byte or with 0 data bytes: completed bytes remain written, busy not set, wel unchanged.
- Busy: counter decrements each clk; busy clears the cycle the counter reaches 0.
- Backdoor load: has priority over an SPI program write to the same cycle. It is ignored while CS is low.
- Simultaneous CS rise and SCK edge in one clk: CS rise wins and the edge is discarded.

Test Plan:
- Backdoor mem[0x123]=0xA5, mem[0x124]=0x3C; send 03 00 01 23 then 16 clocks → MISO returns 0xA5 then 0x3C; OE low within 3 clk of CS rise.
- Send 06, CS high, then 05 + 8 clocks → status 0x02; send 04 then 05 → 0x00.
- With wel=0, send 02 00 00 10 55 then read 0x010 → old value unchanged, busy stays 0.
- Send 06; then 02 00 00 FE 11 22 33 → busy=1 for exactly PROG_CYCLES clk (use PROG_CYCLES=100); mem[0x0FE]=0x11, mem[0x0FF]=0x22, mem[0x000]=0x33 (page wrap); wel=0; a 03 command issued while busy returns OE=0.
- Read at 0xFFF with mem[0xFFF]=0x77, mem[0x000]=0x88, 16 bits → 0x77, 0x88 (array wrap).
- Assert reset mid-read with CS low → OE=0, busy=0, wel=0 immediately; further SCK ignored until CS rises, then the next 03 read succeeds.
